// File: rtl/icache_pkg.sv
// Shared types for the direct-mapped instruction cache: address split, frame layout and FSM states.
package icache_pkg;

    localparam int ICACHE_SETS   = 16;
    localparam int ICACHE_WORD_W = 32;
    localparam int IDXW          = $clog2(ICACHE_SETS);
    localparam int TAGW          = ICACHE_WORD_W - IDXW - 2;

    typedef struct packed {
        logic [TAGW-1:0] tag;
        logic [IDXW-1:0] idx;
        logic [1:0]      bytoff;
    } icachef_t;

    typedef struct packed {
        logic                     valid;
        logic [TAGW-1:0]          tag;
        logic [ICACHE_WORD_W-1:0] data;
    } icache_frame_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with same-cycle hits and a one-word miss fill.
// Optional ICACHE_STATS_EN adds saturating hit_count / miss_count ports.
module icache
    import icache_pkg::*;
#(
    parameter int SETS   = ICACHE_SETS,
    parameter int WORD_W = ICACHE_WORD_W
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              imemREN,
    input  logic [WORD_W-1:0] imemaddr,
    output logic              ihit,
    output logic [WORD_W-1:0] imemload,
    output logic              iREN,
    output logic [WORD_W-1:0] iaddr,
    input  logic              iwait,
    input  logic [WORD_W-1:0] iload
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = WORD_W - IDX_W - 2;

    logic [SETS-1:0]   valid;
    logic [TAG_W-1:0]  tags [SETS];
    logic [WORD_W-1:0] data [SETS];

    icache_state_t     state;
    logic [WORD_W-3:0] miss_word;

    logic [IDX_W-1:0]  req_idx, fill_idx;
    logic [TAG_W-1:0]  req_tag, fill_tag;
    logic              hit, fill_en, miss_start;
    logic              unused_bytoff;

    assign req_idx       = imemaddr[IDX_W+1:2];
    assign req_tag       = imemaddr[WORD_W-1:IDX_W+2];
    assign fill_idx      = miss_word[IDX_W-1:0];
    assign fill_tag      = miss_word[WORD_W-3:IDX_W];
    assign unused_bytoff = ^imemaddr[1:0];

    assign hit        = imemREN && valid[req_idx] && (tags[req_idx] == req_tag);
    assign fill_en    = (state == FETCH) && !iwait;
    assign miss_start = (state == IDLE) && imemREN && !hit;

    assign ihit     = (state == IDLE) && hit;
    assign imemload = ihit ? data[req_idx] : '0;
    assign iREN     = (state == FETCH);
    assign iaddr    = iREN ? {miss_word, 2'b00} : '0;

    // Resetting state also discards an in-flight fill: fill_en needs FETCH.
    always_ff @(posedge CLK, negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            valid <= '0;
        end else begin
            case (state)
                IDLE:    if (miss_start) state <= FETCH;
                FETCH:   if (!iwait)     state <= IDLE;
                default:                 state <= IDLE;
            endcase
            if (fill_en) valid[fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (fill_en) begin
            tags[fill_idx] <= fill_tag;
            data[fill_idx] <= iload;
        end
        if (miss_start) miss_word <= imemaddr[WORD_W-1:2];
    end

`ifdef ICACHE_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge CLK, negedge nRST) begin
        if (!nRST) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (ihit)       hit_count  <= sat_inc(hit_count);
            if (miss_start) miss_count <= sat_inc(miss_count);
        end
    end
`endif

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: stimulus pushes expected hits and fills, a negedge monitor pops and compares.
module tb_icache;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    icache dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .ihit     (ihit),
        .imemload (imemload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t        hit_q[$];
    logic [31:0] fill_q[$];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Monitor: every hit cycle and every completing memory read must match the queued expectation.
    always @(negedge CLK) begin
        if (nRST) begin
            if (ihit) begin
                if (hit_q.size() == 0) begin
                    chk("unexpected_hit_addr", imemaddr, 32'hXXXX_XXXX);
                end else begin
                    exp_t e;
                    e = hit_q.pop_front();
                    chk("hit_addr", imemaddr, e.addr);
                    chk("hit_data", imemload, e.data);
                end
            end
            if (iREN && !iwait) begin
                if (fill_q.size() == 0) begin
                    chk("unexpected_fill_addr", iaddr, 32'hXXXX_XXXX);
                end else begin
                    chk("fill_addr", iaddr, fill_q.pop_front());
                end
            end
        end
    end

    function automatic exp_t mk(input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.addr = a;
        e.data = d;
        return e;
    endfunction

    // Miss on addr, hold iwait for 'waits' FETCH cycles, fill with d, then take one hit cycle.
    task automatic fill(input logic [31:0] a, input logic [31:0] d, input int waits);
        imemREN  = 1'b1;
        imemaddr = a;
        iwait    = 1'b1;
        #1;
        chk("miss_ihit", {31'd0, ihit}, 32'd0);
        chk("miss_imemload", imemload, 32'd0);
        step();
        chk("fetch_iREN", {31'd0, iREN}, 32'd1);
        chk("fetch_iaddr", iaddr, {a[31:2], 2'b00});
        for (int i = 0; i < waits; i++) step();
        iwait = 1'b0;
        iload = d;
        fill_q.push_back({a[31:2], 2'b00});
        hit_q.push_back(mk(a, d));
        step();
        iwait = 1'b1;
        iload = 32'h0;
        step();
        imemREN = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nRST     = 1'b0;
        imemREN  = 1'b0;
        imemaddr = 32'h0;
        iwait    = 1'b1;
        iload    = 32'h0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_ihit", {31'd0, ihit}, 32'd0);
        chk("rst_iREN", {31'd0, iREN}, 32'd0);
        chk("rst_iaddr", iaddr, 32'd0);
        chk("rst_imemload", imemload, 32'd0);
        nRST = 1'b1;
        step();

        // Test 1: cold miss on 0x0 with three wait cycles
        fill(32'h0, 32'h2001_0005, 3);

        // Test 2: repeat hits, byte offset ignored
        imemREN  = 1'b1;
        imemaddr = 32'h0;
        hit_q.push_back(mk(32'h0, 32'h2001_0005));
        #1;
        chk("rehit_iREN", {31'd0, iREN}, 32'd0);
        step();
        chk("rehit_stay_idle", {31'd0, iREN}, 32'd0);
        imemaddr = 32'h2;
        hit_q.push_back(mk(32'h2, 32'h2001_0005));
        step();
        imemREN = 1'b0;
        #1;
        chk("noreq_ihit", {31'd0, ihit}, 32'd0);
        chk("noreq_imemload", imemload, 32'd0);
`ifdef ICACHE_STATS_EN
        chk("stats_miss_count", miss_count, 32'd1);
        chk("stats_hit_count", hit_count, 32'd3);
`endif

        // Test 3: conflict in set 0
        fill(32'h40, 32'hAAAA_0040, 1);
        fill(32'h0, 32'hBBBB_0000, 0);
        imemREN  = 1'b1;
        imemaddr = 32'h0;
        hit_q.push_back(mk(32'h0, 32'hBBBB_0000));
        step();
        fill(32'h40, 32'hCCCC_0040, 0);

        // Test 4: redirect while the fill for 0x10 is outstanding
        imemREN  = 1'b1;
        imemaddr = 32'h10;
        iwait    = 1'b1;
        #1;
        chk("redir_miss", {31'd0, ihit}, 32'd0);
        step();
        chk("redir_iaddr0", iaddr, 32'h10);
        imemaddr = 32'h20;
        step();
        step();
        chk("redir_iaddr_held", iaddr, 32'h10);
        iwait = 1'b0;
        iload = 32'h1111_0010;
        fill_q.push_back(32'h10);
        step();
        iwait = 1'b1;
        #1;
        chk("redir_new_miss", {31'd0, ihit}, 32'd0);
        step();
        chk("redir_iaddr1", iaddr, 32'h20);
        iwait = 1'b0;
        iload = 32'h2222_0020;
        fill_q.push_back(32'h20);
        hit_q.push_back(mk(32'h20, 32'h2222_0020));
        step();
        iwait = 1'b1;
        step();
        imemaddr = 32'h10;
        hit_q.push_back(mk(32'h10, 32'h1111_0010));
        step();
        imemREN = 1'b0;
        #1;

        // Test 5: reset during FETCH discards the fill and clears all frames
        imemREN  = 1'b1;
        imemaddr = 32'h80;
        step();
        chk("rstfetch_iREN_before", {31'd0, iREN}, 32'd1);
        iwait = 1'b0;
        iload = 32'hDEAD_BEEF;
        nRST  = 1'b0;
        #1;
        chk("rstfetch_iREN_after", {31'd0, iREN}, 32'd0);
        chk("rstfetch_iaddr_after", iaddr, 32'd0);
        step();
        iwait   = 1'b1;
        imemREN = 1'b0;
`ifdef ICACHE_STATS_EN
        chk("stats_rst_hit_count", hit_count, 32'd0);
        chk("stats_rst_miss_count", miss_count, 32'd0);
`endif
        nRST = 1'b1;
        step();
        fill(32'h0, 32'h3333_0000, 0);
        fill(32'h80, 32'h4444_0080, 2);

        step();
        chk("hit_q_drained", hit_q.size(), 32'd0);
        chk("fill_q_drained", fill_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
